mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter and sequencer for the shared 1-of-4 selector datapath (`mux1b4to1`-style: data inputs a/b/c/d, selects s1/s2). Four requesters compete for the single output path. The block grants one requester at a time and drives the s1/s2 selects to route it. It moves data to a downstream consumer under a valid/ready handshake and forces a grant change after a bounded burst, so no requester can starve the others.

## Interface
- `WIDTH`, 8: data width per requester.
- `MAX_HOLD`, 4: maximum transfers per grant; legal range ≥1.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  4  per-requester request; bit i = requester i (0→a, 1→b, 2→c, 3→d).
- `data_in`  in  4*WIDTH  requester data; requester i at bits [i*WIDTH +: WIDTH].
- `out_ready`  in  1  downstream accepts a beat this cycle.
- `gnt`  out  4  one-hot grant, registered; all-zero when idle.
- `s1`  out  1  select MSB, registered; {s1,s2} = owner index (00 a, 01 b, 10 c, 11 d).
- `s2`  out  1  select LSB, registered.
- `out_valid`  out  1  = |(gnt & req), combinational.
- `dout`  out  WIDTH  data_in slice selected by {s1,s2}, combinational.
- `busy`  out  1  high in GRANT state.

## Operation
- State machine: IDLE, GRANT. Internal registers:
  - `ptr[1:0]`: highest-priority index for the next arbitration.
  - `owner[1:0]`: index of the current grant holder.
  - `cnt`: transfer counter, $clog2(MAX_HOLD+1) bits.
- Arbitration: scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first with req=1 wins.
- IDLE:
  - gnt=0; {s1,s2} hold their last value.
  - If any req=1: the winner is loaded into owner, gnt, and {s1,s2}; cnt=0; go to GRANT.
- GRANT:
  - A transfer occurs on a cycle with out_valid & out_ready; cnt increments on each transfer.
  - Release is triggered by either of:
    - req[owner]=0 sampled at the edge, or
    - a transfer with cnt == MAX_HOLD-1 (the MAX_HOLD-th beat).
  - On release, ptr ← owner+1 (mod 4), and arbitration uses the new ptr.
  - If another request is present, hand off directly to GRANT with the new owner at the next edge, cnt=0, no dead cycle.
  - The releasing owner may win again only when it is the sole requester.
  - If no request is present, go to IDLE, gnt=0.
- Without a release trigger, the grant is held through stalls (out_ready=0) indefinitely; cnt is unchanged.
- Arithmetic:
  - ptr and owner wrap 3→0.
  - cnt never exceeds MAX_HOLD-1; it resets to 0 on every new grant.
- Reset values: state=IDLE, gnt=0000, s1=0, s2=0, ptr=0, owner=0, cnt=0, busy=0, out_valid=0.

## Timing
- Request-to-grant latency: 1 clock. req rising before edge N gives gnt at N.
- {s1,s2} and gnt change on the same edge, so dout is consistent with gnt in every cycle.
- Handoff latency: the edge that completes the final beat also installs the next owner.
- A requester dropping req mid-burst: out_valid falls the same cycle (combinational); the grant is removed at the next edge.
- Simultaneous release and new requests: the new requests are included in the arbitration at that edge.
- Reset asserted mid-burst:
  - All outputs take their reset values immediately, without waiting for a clock edge.
  - The partial burst is dropped; there is no recovery.
  - After rst deasserts, requester 0 has top priority.
- out_ready is ignored outside GRANT.

## Test plan
- Reset then single request:
  - rst 1→0, req=0100 →
    - one cycle later gnt=0100, {s1,s2}=10, busy=1;
    - with out_ready=1 and data_in c=8'h5A, dout=8'h5A, out_valid=1.
- Burst limit (MAX_HOLD=4): req=0011 held, out_ready=1 →
  - gnt=0001 for exactly 4 transfers;
  - then gnt=0010 on the next edge with no gap;
  - then 0001 again after 4 more.
- Stall: owner requester 0, out_ready=0 for 10 cycles, req=1111 →
  - gnt stays 0001 and cnt is unchanged;
  - after 4 transfers resume, gnt=0010.
- Early drop: owner requester 2 drops req after 1 transfer, req[3]=1 →
  - out_valid=0 that cycle;
  - next edge gnt=1000, {s1,s2}=11.
- Round-robin wrap: owner 3 releases with req=1001 → next gnt=0001 (ptr wrapped to 0).
- Reset mid-burst: assert rst between edges during GRANT →
  - gnt=0000, s1=s2=0, busy=0 immediately;
  - after release with req=1111, first gnt=0001.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 selector path. One owner at a time
// drives {s1,s2}, and a grant is forced to move on after MAX_HOLD beats.
module mux4_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int MAX_HOLD = 4,
  localparam int CW = $clog2(MAX_HOLD + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] data_in,
  input  logic               out_ready,
  output logic [3:0]         gnt,
  output logic               s1,
  output logic               s2,
  output logic               out_valid,
  output logic [WIDTH-1:0]   dout,
  output logic               busy,
  output logic               dbg_state_o,
  output logic [1:0]         dbg_ptr_o,
  output logic [1:0]         dbg_owner_o,
  output logic [CW-1:0]      dbg_cnt_o
);

  // Downstream handshake: a beat moves on any cycle where out_valid and
  // out_ready are both high; out_valid never waits on out_ready.

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_HOLD - 1);

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;

  logic          xfer;
  logic          release_now;
  logic [1:0]    next_ptr;
  logic [1:0]    winner;

  // First requester at or after p, wrapping mod 4.
  function automatic logic [1:0] pick(input logic [1:0] p, input logic [3:0] r);
    logic [1:0] idx;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      owner_q <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
    end
  end

  assign out_valid = |(gnt_q & req);
  assign xfer      = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    release_now = 1'b0;
    next_ptr    = owner_q + 2'd1;
    winner      = 2'd0;
    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (|req) begin
          winner  = pick(ptr_q, req);
          owner_d = winner;
          gnt_d   = 4'b0001 << winner;
          sel_d   = winner;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        release_now = ~req[owner_q] | (xfer & (cnt_q == LAST_BEAT));
        if (release_now) begin
          // The old owner sits last in the new scan, so it only wins alone.
          ptr_d = next_ptr;
          if (|req) begin
            winner  = pick(next_ptr, req);
            owner_d = winner;
            gnt_d   = 4'b0001 << winner;
            sel_d   = winner;
            cnt_d   = '0;
          end else begin
            gnt_d   = 4'b0000;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else if (xfer) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_comb begin
    dout = data_in[int'(sel_q)*WIDTH +: WIDTH];
  end

  assign gnt         = gnt_q;
  assign s1          = sel_q[1];
  assign s2          = sel_q[0];
  assign busy        = (state_q == GRANT);
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;
  assign dbg_owner_o = owner_q;
  assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: expected beats are queued by the
// stimulus and matched by a monitor on every accepted transfer.
module tb_mux4_rr_arbiter;

  localparam int WIDTH = 8;
  localparam int MAX_HOLD = 4;
  localparam int CW = $clog2(MAX_HOLD + 1);

  logic               clk;
  logic               rst;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] data_in;
  logic               out_ready;
  logic [3:0]         gnt;
  logic               s1;
  logic               s2;
  logic               out_valid;
  logic [WIDTH-1:0]   dout;
  logic               busy;
  logic               dbg_state_o;
  logic [1:0]         dbg_ptr_o;
  logic [1:0]         dbg_owner_o;
  logic [CW-1:0]      dbg_cnt_o;

  int n_checks = 0;
  int n_fail = 0;

  // Each entry is {owner index, data} for one expected beat.
  logic [WIDTH+1:0] exp_q[$];

  localparam logic [7:0] DA = 8'hA0;
  localparam logic [7:0] DB = 8'hB1;
  localparam logic [7:0] DC = 8'h5A;
  localparam logic [7:0] DD = 8'hD3;

  mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .out_ready(out_ready),
    .gnt(gnt), .s1(s1), .s2(s2), .out_valid(out_valid), .dout(dout), .busy(busy),
    .dbg_state_o(dbg_state_o), .dbg_ptr_o(dbg_ptr_o), .dbg_owner_o(dbg_owner_o),
    .dbg_cnt_o(dbg_cnt_o)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver and check helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_beats(input logic [1:0] idx, input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({idx, d});
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [WIDTH+1:0] e;
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got sel=%0d dout=%0h with empty queue at %0t",
                 {s1, s2}, dout, $time);
      end else begin
        e = exp_q.pop_front();
        if ({s1, s2, dout} !== e) begin
          n_fail++;
          $display("FAIL beat: got sel=%0d dout=%0h expected sel=%0d dout=%0h at %0t",
                   {s1, s2}, dout, e[WIDTH+1:WIDTH], e[WIDTH-1:0], $time);
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst = 1'b1;
    req = 4'b0000;
    out_ready = 1'b0;
    data_in = {DD, DC, DB, DA};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_s1", 32'(s1), 32'h0);
    check("rst_s2", 32'(s2), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_ptr", 32'(dbg_ptr_o), 32'h0);

    // Single request from c
    tick();
    rst = 1'b0;
    req = 4'b0100;
    tick();
    @(negedge clk);
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_sel", 32'({s1, s2}), 32'h2);
    check("single_busy", 32'(busy), 32'h1);
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_dout", 32'(dout), 32'(DC));
    tick();
    out_ready = 1'b1;
    push_beats(2'd2, DC, 1);
    tick();
    req = 4'b0000;
    out_ready = 1'b0;
    tick();
    @(negedge clk);
    check("idle_gnt", 32'(gnt), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_sel_hold", 32'({s1, s2}), 32'h2);

    // Burst limit: a x4, b x4, a x4 with no gap
    tick();
    req = 4'b0011;
    out_ready = 1'b1;
    push_beats(2'd0, DA, 4);
    push_beats(2'd1, DB, 4);
    push_beats(2'd0, DA, 4);
    tick();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("burst_gnt", 32'(gnt), (c >= 4 && c < 8) ? 32'h2 : 32'h1);
      check("burst_cnt", 32'(dbg_cnt_o), 32'(c % 4));
      tick();
    end
    req = 4'b0000;
    out_ready = 1'b0;
    tick();

    // Stall with owner a while everyone requests
    req = 4'b0001;
    tick();
    req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_gnt", 32'(gnt), 32'h1);
      check("stall_cnt", 32'(dbg_cnt_o), 32'h0);
      tick();
    end
    out_ready = 1'b1;
    push_beats(2'd0, DA, 4);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("resume_gnt", 32'(gnt), 32'h1);
      check("resume_cnt", 32'(dbg_cnt_o), 32'(c));
      tick();
    end
    out_ready = 1'b0;
    @(negedge clk);
    check("resume_handoff_gnt", 32'(gnt), 32'h2);
    check("resume_handoff_sel", 32'({s1, s2}), 32'h1);

    // Early drop by c hands off to d
    tick();
    req = 4'b1100;
    tick();
    @(negedge clk);
    check("drop_pre_gnt", 32'(gnt), 32'h4);
    tick();
    out_ready = 1'b1;
    push_beats(2'd2, DC, 1);
    tick();
    req = 4'b1000;
    @(negedge clk);
    check("drop_valid", 32'(out_valid), 32'h0);
    check("drop_gnt_held", 32'(gnt), 32'h4);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("drop_next_gnt", 32'(gnt), 32'h8);
    check("drop_next_sel", 32'({s1, s2}), 32'h3);

    // Wrap from d back to a
    tick();
    req = 4'b1001;
    out_ready = 1'b1;
    push_beats(2'd3, DD, 4);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("wrap_gnt_d", 32'(gnt), 32'h8);
      tick();
    end
    out_ready = 1'b0;
    @(negedge clk);
    check("wrap_gnt_a", 32'(gnt), 32'h1);
    check("wrap_sel", 32'({s1, s2}), 32'h0);
    check("wrap_ptr", 32'(dbg_ptr_o), 32'h0);

    // Reset mid-burst
    tick();
    out_ready = 1'b1;
    push_beats(2'd0, DA, 1);
    tick();
    #2;
    rst = 1'b1;
    out_ready = 1'b0;
    #1;
    check("midrst_gnt", 32'(gnt), 32'h0);
    check("midrst_s1", 32'(s1), 32'h0);
    check("midrst_s2", 32'(s2), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_valid", 32'(out_valid), 32'h0);
    tick();
    rst = 1'b0;
    req = 4'b1111;
    tick();
    @(negedge clk);
    check("postrst_gnt", 32'(gnt), 32'h1);
    check("postrst_sel", 32'({s1, s2}), 32'h0);
    tick();
    req = 4'b0000;
    tick();
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
